// File: rtl/ntt_input_loader.sv
// Streams one polynomial into the banked coefficient memory, one row of 2*NTT_CORE
// coefficients per write, then hands off to the NTT controller and waits for it.
module ntt_input_loader #(
   parameter int RING_SIZE     = 1024,
   parameter int LOG_RING_SIZE = 10,
   parameter int NTT_CORE      = 8,
   parameter int LOG_NTT_CORE  = 3,
   parameter int DATA_SIZE     = 64
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     load_req,
   input  logic                                     in_valid,
   input  logic [DATA_SIZE-1:0]                     in_data,
   input  logic                                     in_last,
   output logic                                     in_ready,
   output logic                                     wr_en,
   output logic [LOG_RING_SIZE-LOG_NTT_CORE-2:0]    wr_addr,
   output logic [2*NTT_CORE*DATA_SIZE-1:0]          wr_data,
   output logic                                     ntt_start,
   input  logic                                     ntt_finished,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     err_len
);

   localparam int BANKS  = 2 * NTT_CORE;
   localparam int SLOT_W = LOG_NTT_CORE + 1;
   localparam int ROW_W  = LOG_RING_SIZE - LOG_NTT_CORE - 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_START = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   logic [1:0]                   state_reg;
   logic [LOG_RING_SIZE-1:0]     cnt_reg;
   logic [DATA_SIZE-1:0]         row_buf_reg [BANKS];
   logic [SLOT_W-1:0]            slot;
   logic [ROW_W-1:0]             row;
   logic                         accept;
   logic                         slot_last;
   logic                         cnt_last;
   logic [BANKS*DATA_SIZE-1:0]   row_next;

   assign slot      = cnt_reg[SLOT_W-1:0];
   assign row       = cnt_reg[LOG_RING_SIZE-1:SLOT_W];
   assign in_ready  = (state_reg == S_FILL);
   assign busy      = (state_reg != S_IDLE);
   assign accept    = in_valid && in_ready;
   assign slot_last = &slot;
   assign cnt_last  = (cnt_reg == LOG_RING_SIZE'(RING_SIZE - 1));

   // The closing coefficient of a row goes straight to the output register,
   // so a row write never costs an accept cycle.
   genvar gi;
   generate
      for (gi = 0; gi < BANKS; gi++) begin : g_row
         if (gi == BANKS - 1) begin : g_last
            assign row_next[gi*DATA_SIZE +: DATA_SIZE] = in_data;
         end else begin : g_buf
            assign row_next[gi*DATA_SIZE +: DATA_SIZE] = row_buf_reg[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         ntt_start <= 1'b0;
         done      <= 1'b0;
         err_len   <= 1'b0;
         for (int b = 0; b < BANKS; b++) begin
            row_buf_reg[b] <= '0;
         end
      end else begin
         wr_en     <= 1'b0;
         ntt_start <= 1'b0;
         done      <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (load_req) begin
                  state_reg <= S_FILL;
                  cnt_reg   <= '0;
                  err_len   <= 1'b0;
               end
            end
            S_FILL: begin
               if (accept) begin
                  // A premature in_last abandons the polynomial, partial row included.
                  if (in_last && !cnt_last) begin
                     err_len   <= 1'b1;
                     state_reg <= S_IDLE;
                  end else begin
                     row_buf_reg[slot] <= in_data;
                     cnt_reg           <= cnt_reg + 1'b1;
                     if (slot_last) begin
                        wr_en   <= 1'b1;
                        wr_addr <= row;
                        wr_data <= row_next;
                     end
                     if (cnt_last) begin
                        state_reg <= S_START;
                        if (!in_last) begin
                           err_len <= 1'b1;
                        end
                     end
                  end
               end
            end
            S_START: begin
               // First START cycle carries the final row write; the second carries ntt_start.
               if (!ntt_start) begin
                  ntt_start <= 1'b1;
               end else begin
                  state_reg <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (ntt_finished) begin
                  done      <= 1'b1;
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ntt_input_loader.md
Name: ntt_input_loader

Overview:
- Upstream feeder for the NTT controller/datapath.
- Accepts one polynomial of RING_SIZE coefficients over a valid/ready stream, in natural order.
- Packs 2*NTT_CORE consecutive coefficients into one row and writes each row into the banked coefficient memory.
- After the last row is written, pulses the controller's start, then waits for its finished pulse before accepting a new polynomial.

Parameters:
RING_SIZE, 1024, polynomial length (power of two)
LOG_RING_SIZE, 10, log2(RING_SIZE)
NTT_CORE, 8, butterfly units; memory has 2*NTT_CORE banks
LOG_NTT_CORE, 3, log2(NTT_CORE)
DATA_SIZE, 64, coefficient width in bits

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (sampled on clk; 0 = reset)
load_req  in  1  one-cycle request to begin loading a polynomial
in_valid  in  1  coefficient valid
in_data  in  DATA_SIZE  coefficient
in_last  in  1  marks the final coefficient of the polynomial
in_ready  out  1  loader accepts a coefficient this cycle
wr_en  out  1  row write strobe to all 2*NTT_CORE banks
wr_addr  out  LOG_RING_SIZE-LOG_NTT_CORE-1  row address, common to all banks
wr_data  out  2*NTT_CORE*DATA_SIZE  row data; bank b occupies bits [b*DATA_SIZE +: DATA_SIZE]
ntt_start  out  1  one-cycle start pulse to the NTT controller
ntt_finished  in  1  one-cycle finished pulse from the NTT controller
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the NTT has completed
err_len  out  1  sticky flag: length/in_last mismatch

Behaviour:
- Reset (reset==0 at an edge), including mid-operation:
  - state=IDLE; coefficient counter, row buffer and wr_data cleared.
  - in_ready, wr_en, wr_addr, ntt_start, done, err_len and busy all 0.
  - Any partial polynomial is discarded.
- Accept: a coefficient is accepted when in_valid && in_ready.
- Counter: cnt is LOG_RING_SIZE bits.
  - slot = cnt[LOG_NTT_CORE:0] selects the bank.
  - row = cnt[LOG_RING_SIZE-1:LOG_NTT_CORE+1] selects the row.
  - Coefficient k therefore goes to bank k mod 2*NTT_CORE, row k>>(LOG_NTT_CORE+1).
- States:
  - IDLE: in_ready=0. load_req -> FILL; cnt=0; err_len cleared.
  - FILL: in_ready=1 (combinational from state).
    - Each accepted coefficient is stored into the row buffer at slot; cnt increments.
    - When the accepted slot is 2*NTT_CORE-1, on the next cycle: wr_en=1, wr_addr=row, wr_data = full row including that coefficient (captured into the output register, so there is no stall).
    - The next row may be accepted in the same cycle as the write.
    - When the accepted cnt is RING_SIZE-1 -> START (the final row write occurs in START's first cycle).
  - START: ntt_start=1 for exactly one cycle, one cycle after the final wr_en; -> WAIT_NTT.
  - WAIT_NTT: in_ready=0; wait for ntt_finished. On it, done=1 the following cycle; -> IDLE.
- Latency with in_valid held high:
  - Accept N at cycle t0+N.
  - Row r wr_en at t0+16r+16 (NTT_CORE=8).
  - Final wr_en at t0+RING_SIZE.
  - ntt_start at t0+RING_SIZE+1.
- in_last rules:
  - in_last on a coefficient with cnt != RING_SIZE-1: set err_len; that coefficient is dropped; no write of the partial row; no ntt_start; -> IDLE.
  - cnt == RING_SIZE-1 accepted without in_last: set err_len but complete normally.
- err_len stays set until reset or the next accepted load_req.
- Ignored inputs:
  - load_req outside IDLE.
  - ntt_finished outside WAIT_NTT.
  - in_valid while in_ready=0.
- Simultaneous events:
  - load_req and in_valid in the IDLE cycle: only load_req takes effect; no coefficient is accepted.
  - ntt_finished in the same cycle as ntt_start: ignored, because the state is still START.
- Wrap-around: cnt wraps to 0 after RING_SIZE-1. wr_addr is never larger than RING_SIZE/(2*NTT_CORE)-1.
- wr_en is never high in IDLE or WAIT_NTT. wr_addr and wr_data hold their last values when wr_en=0.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release -> all outputs 0 and busy=0; in_valid pulses produce no wr_en.
- Full load: load_req, then 1024 back-to-back coefficients with value k and in_last on k=1023 -> 64 wr_en pulses; row r carries k=16r..16r+15 with bank b = 16r+b; single ntt_start one cycle after row 63; err_len=0.
- Bubbles: in_valid toggling pseudo-randomly -> identical row contents; wr_en only after each 16th accept; no extra ntt_start.
- Early in_last at k=100 -> err_len=1; 6 wr_en pulses (rows 0-5), no row 6 write; no ntt_start; busy=0 next cycle.
- Handshake with controller: ntt_finished pulsed 50 cycles after ntt_start -> done=1 exactly one cycle later; in_ready=0 throughout; a load_req during WAIT_NTT is ignored.
- Mid-load reset: reset=0 at k=500 -> everything cleared; a new load_req plus a full stream completes correctly starting at row 0.
